// File: rtl/vector_loader.sv
// Collects a_i/b_i element pairs into a four-entry vector pair.
// The full vector is held until the dot-product stage consumes it.
module vector_loader #(
  parameter int bits_num = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [bits_num-1:0] in_a,
  input  logic [bits_num-1:0] in_b,
  input  logic                in_last,
  output logic [bits_num-1:0] a1,
  output logic [bits_num-1:0] a2,
  output logic [bits_num-1:0] a3,
  output logic [bits_num-1:0] a4,
  output logic [bits_num-1:0] b1,
  output logic [bits_num-1:0] b2,
  output logic [bits_num-1:0] b3,
  output logic [bits_num-1:0] b4,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [2:0]          count
);

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t              state;
  logic [2:0]          cnt;
  logic [bits_num-1:0] va [4];
  logic [bits_num-1:0] vb [4];

  // Handshake flags come straight from the state register.
  assign in_ready  = (state == FILL);
  assign out_valid = (state == HOLD);
  assign count     = cnt;

  assign a1 = va[0];
  assign a2 = va[1];
  assign a3 = va[2];
  assign a4 = va[3];
  assign b1 = vb[0];
  assign b2 = vb[1];
  assign b3 = vb[2];
  assign b4 = vb[3];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= FILL;
      cnt   <= 3'd0;
      for (int i = 0; i < 4; i++) begin
        va[i] <= '0;
        vb[i] <= '0;
      end
    end else if (clr) begin
      state <= FILL;
      cnt   <= 3'd0;
      for (int i = 0; i < 4; i++) begin
        va[i] <= '0;
        vb[i] <= '0;
      end
    end else if (state == FILL) begin
      if (in_valid) begin
        // Slots past an early in_last are zero-padded.
        for (int i = 0; i < 4; i++) begin
          if (3'(i) == cnt) begin
            va[i] <= in_a;
            vb[i] <= in_b;
          end else if (in_last && (3'(i) > cnt)) begin
            va[i] <= '0;
            vb[i] <= '0;
          end
        end
        if (in_last || cnt == 3'd3) begin
          state <= HOLD;
          cnt   <= 3'd4;
        end else begin
          cnt <= cnt + 3'd1;
        end
      end
    end else if (out_ready) begin
      state <= FILL;
      cnt   <= 3'd0;
    end
  end

endmodule

// File: tb/tb_vector_loader.sv
// Directed bench for vector_loader.
module tb_vector_loader;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clr;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_a;
  logic [3:0] in_b;
  logic       in_last;
  logic [3:0] a1, a2, a3, a4;
  logic [3:0] b1, b2, b3, b4;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] count;

  int n_cmp = 0;
  int n_err = 0;

  logic [15:0] av, bv, av_hold, bv_hold;
  assign av = {a1, a2, a3, a4};
  assign bv = {b1, b2, b3, b4};

  vector_loader #(.bits_num(4)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_last(in_last),
    .a1(a1), .a2(a2), .a3(a3), .a4(a4),
    .b1(b1), .b2(b2), .b3(b3), .b4(b4),
    .out_valid(out_valid), .out_ready(out_ready),
    .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [3:0] a, input logic [3:0] b,
                     input logic last);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_last  = last;
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b0;
    clr       = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_elems", {av, bv}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // four pairs, downstream ready
    put(4'd1, 4'd2, 1'b0);
    chk("fill_cnt1", 32'(count), 32'd1);
    put(4'd3, 4'd4, 1'b0);
    put(4'd5, 4'd6, 1'b0);
    put(4'd7, 4'd8, 1'b0);
    chk("full_a", 32'(av), 32'h1357);
    chk("full_b", 32'(bv), 32'h2468);
    chk("full_valid", 32'(out_valid), 32'd1);
    chk("full_count", 32'(count), 32'd4);
    tick();
    chk("consumed_valid", 32'(out_valid), 32'd0);
    chk("consumed_count", 32'(count), 32'd0);
    chk("consumed_keep", 32'(av), 32'h1357);

    // early in_last, downstream stalled
    out_ready = 1'b0;
    put(4'd15, 4'd15, 1'b0);
    put(4'd9, 4'd1, 1'b1);
    chk("short_a", 32'(av), 32'hF900);
    chk("short_b", 32'(bv), 32'hF100);
    chk("short_count", 32'(count), 32'd4);
    chk("short_valid", 32'(out_valid), 32'd1);

    // held vector under backpressure with traffic waiting
    av_hold  = av;
    bv_hold  = bv;
    in_valid = 1'b1;
    in_a     = 4'd2;
    in_b     = 4'd3;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("hold_in_ready", 32'(in_ready), 32'd0);
      chk("hold_stable", {av, bv}, {av_hold, bv_hold});
    end
    out_ready = 1'b1;
    tick();
    chk("hold_consume_valid", 32'(out_valid), 32'd0);
    chk("hold_consume_count", 32'(count), 32'd0);
    tick();
    chk("hold_next_count", 32'(count), 32'd1);
    chk("hold_next_a1", 32'(a1), 32'd2);
    in_valid = 1'b0;

    // clr mid-vector
    put(4'd4, 4'd5, 1'b0);
    chk("pre_clr_count", 32'(count), 32'd2);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr_count", 32'(count), 32'd0);
    chk("clr_elems", {av, bv}, 32'd0);
    out_ready = 1'b0;
    put(4'd10, 4'd11, 1'b0);
    put(4'd12, 4'd13, 1'b0);
    put(4'd14, 4'd15, 1'b0);
    put(4'd3, 4'd1, 1'b1);
    chk("refill_a", 32'(av), 32'hACE3);
    chk("refill_b", 32'(bv), 32'hBDF1);
    chk("refill_valid", 32'(out_valid), 32'd1);

    // clr with a pair offered while holding
    clr      = 1'b1;
    in_valid = 1'b1;
    in_a     = 4'd5;
    in_b     = 4'd5;
    tick();
    clr      = 1'b0;
    in_valid = 1'b0;
    chk("clrhold_valid", 32'(out_valid), 32'd0);
    chk("clrhold_count", 32'(count), 32'd0);
    chk("clrhold_elems", {av, bv}, 32'd0);

    // asynchronous reset while holding
    put(4'd1, 4'd2, 1'b0);
    put(4'd3, 4'd4, 1'b0);
    put(4'd5, 4'd6, 1'b0);
    put(4'd7, 4'd8, 1'b0);
    chk("pre_arst_valid", 32'(out_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_elems", {av, bv}, 32'd0);
    chk("arst_count", 32'(count), 32'd0);
    chk("arst_in_ready", 32'(in_ready), 32'd1);
    tick();
    rst_n = 1'b1;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
